mw_pipe_reg: RTL and testbench
==============================

# mw_pipe_reg

Parametrised MEM→WB pipeline register for the five-stage MIPS core. It latches the memory-stage bundle: instruction, PC+8, ALU result, load data, destination register and write enable. It adds stall (hold), flush (bubble) and a valid bit, and decodes the write-back source class from the instruction. It also drives the final register-file write port (data, address, enable) and keeps a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 32, datapath width of IR/PC8/AO/DR and write data
- RADDR_W, 5, register-file address width
- PC8_RST, 32'h0000_3008, reset/flush value of pc8_w
- CNT_W, 32, retired-instruction counter width

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- stall_i  in  1  hold all registers this cycle
- flush_i  in  1  load a bubble instead of the M-stage bundle
- ir_i  in  DATA_W  M-stage instruction
- pc8_i  in  DATA_W  M-stage PC+8
- ao_i  in  DATA_W  M-stage ALU result / address
- dr_i  in  DATA_W  data-memory read data
- rfa3_i  in  RADDR_W  destination register
- regwrite_i  in  1  M-stage write enable
- ir_w, pc8_w, ao_w, dr_w  out  DATA_W  registered copies
- rfa3_w  out  RADDR_W  registered destination
- res_w  out  2  write-back class: 00 NW, 01 ALU, 10 DM, 11 PC
- valid_w  out  1  W stage holds a real instruction
- we_w  out  1  register-file write enable
- wd_w  out  DATA_W  register-file write data
- retired_o  out  CNT_W  retired-instruction count

## Operation
- Update priority on each edge: reset > flush_i > stall_i > load.
- Reset: ir/ao/dr_w=0, pc8_w=PC8_RST, rfa3_w=0, res_w=00, valid_w=0, regwrite state=0, retired_o=0.
- Flush: same values as reset, except retired_o, which still follows its own rule below.
- Stall: every register holds its value.
- Load: copy inputs and set valid_w=1.
- res_w is registered and decoded from ir_i at load. op/func fields are IR[31:26]/IR[5:0].
  - R-type addu(100001), subu(100011), movz(001010) → ALU.
  - ori(001101), lui(001111) → ALU.
  - lw(100011) → DM.
  - jal(000011) and R-type jalr(001001) → PC.
  - Everything else → NW.
- we_w = valid_w & regwrite_state & (rfa3_w≠0) & (res_w≠NW). Writes to register 0 are never asserted.
- wd_w (combinational from registered state): ALU→ao_w, DM→load value, PC→pc8_w, NW→0.
- retired_o increments by 1 on an edge where valid_w=1 and stall_i=0, evaluated before the edge. It wraps modulo 2^CNT_W. A held (stalled) instruction counts once.

## Timing
- Latency: exactly one cycle from M-stage inputs to W outputs.
- we_w and wd_w are valid in the same cycle as the registered fields, so they can feed the forwarding mux directly.
- Stall and flush in the same cycle: flush wins and a bubble is loaded.
- Reset mid-stall or mid-flush: reset values apply; retired_o returns to 0.
- No handshake; stall_i and flush_i are level-sampled each edge.

## Configuration
- Macro: MW_PIPE_REG_LOADEXT_EN.
- Defined:
  - lb(100000), lbu(100100), lh(100001), lhu(100101) also decode to DM.
  - DM write data is extracted little-endian from dr_w using ao_w[1:0] (byte) or ao_w[1] (half).
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Undefined:
  - Those opcodes decode to NW.
  - DM write data is dr_w unchanged.

## Test plan
- Reset held for 2 cycles → pc8_w=32'h0000_3008, res_w=00, valid_w=0, we_w=0, retired_o=0.
- Load addu with rfa3_i=8, ao_i=32'h1234, regwrite_i=1 → next cycle res_w=01, we_w=1, wd_w=32'h1234, retired_o increments after one more edge.
- Load jal with rfa3_i=31, pc8_i=32'h3010 → wd_w=32'h3010, we_w=1. Then addu with rfa3_i=0 → we_w=0.
- lw loaded, then stall_i high for 3 cycles → all outputs frozen, retired_o increments only once, on the first un-stalled edge. Asserting flush_i together with stall_i → valid_w=0 next cycle.
- With MW_PIPE_REG_LOADEXT_EN defined: lb with dr_i=32'h80FF_7F01, ao_i[1:0]=2 → wd_w=32'hFFFF_FFFF. lhu with ao_i[1]=1 → wd_w=32'h0000_80FF. Without the macro, lb → res_w=00, we_w=0.
- CNT_W=4: 17 valid retirements → retired_o=1 (wrap).

Source files
------------

// File: rtl/mw_pipe_reg_if.sv
// MEM->WB pipeline register bundle.
// master: drives the M-stage side and observes the W-stage side.
// slave:  the pipeline register itself.
interface mw_pipe_reg_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
);
    // M-stage side
    logic                stall_i;
    logic                flush_i;
    logic [DATA_W-1:0]   ir_i;
    logic [DATA_W-1:0]   pc8_i;
    logic [DATA_W-1:0]   ao_i;
    logic [DATA_W-1:0]   dr_i;
    logic [RADDR_W-1:0]  rfa3_i;
    logic                regwrite_i;

    // W-stage side
    logic [DATA_W-1:0]   ir_w;
    logic [DATA_W-1:0]   pc8_w;
    logic [DATA_W-1:0]   ao_w;
    logic [DATA_W-1:0]   dr_w;
    logic [RADDR_W-1:0]  rfa3_w;
    logic [1:0]          res_w;
    logic                valid_w;
    logic                we_w;
    logic [DATA_W-1:0]   wd_w;
    logic [CNT_W-1:0]    retired_o;

    modport master (
        output stall_i, flush_i, ir_i, pc8_i, ao_i, dr_i, rfa3_i, regwrite_i,
        input  ir_w, pc8_w, ao_w, dr_w, rfa3_w, res_w, valid_w, we_w, wd_w, retired_o
    );

    modport slave (
        input  stall_i, flush_i, ir_i, pc8_i, ao_i, dr_i, rfa3_i, regwrite_i,
        output ir_w, pc8_w, ao_w, dr_w, rfa3_w, res_w, valid_w, we_w, wd_w, retired_o
    );
endinterface

// File: rtl/mw_pipe_reg.sv
// MEM->WB pipeline register for the five-stage MIPS core.
// Latches the M-stage bundle with stall/flush/valid, decodes the write-back
// class, drives the register-file write port and counts retired instructions.
// Optional feature: define MW_PIPE_REG_LOADEXT_EN to add lb/lbu/lh/lhu with
// little-endian sub-word extraction of the load data.
module mw_pipe_reg #(
    parameter int unsigned        DATA_W  = 32,
    parameter int unsigned        RADDR_W = 5,
    parameter logic [DATA_W-1:0]  PC8_RST = 32'h0000_3008,
    parameter int unsigned        CNT_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    mw_pipe_reg_if.slave  bus
);

    // Write-back classes
    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;
    localparam logic [1:0] RES_PC  = 2'b11;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
`ifdef MW_PIPE_REG_LOADEXT_EN
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
`endif

    // SPECIAL function codes
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // Registered W-stage state
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_pc8;
    logic [DATA_W-1:0]   r_ao;
    logic [DATA_W-1:0]   r_dr;
    logic [RADDR_W-1:0]  r_rfa3;
    logic [1:0]          r_res;
    logic                r_valid;
    logic                r_regwrite;
    logic [CNT_W-1:0]    r_retired;

    // Combinational helpers
    logic [5:0]          w_op;
    logic [5:0]          w_func;
    logic [1:0]          w_res_dec;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_wd;
    logic                w_we;

    assign w_op   = bus.ir_i[31:26];
    assign w_func = bus.ir_i[5:0];

    // Decode the write-back class of the incoming M-stage instruction
    always_comb begin
        w_res_dec = RES_NW;
        case (w_op)
            OP_SPECIAL: begin
                case (w_func)
                    FN_ADDU, FN_SUBU, FN_MOVZ: w_res_dec = RES_ALU;
                    FN_JALR:                   w_res_dec = RES_PC;
                    default:                   w_res_dec = RES_NW;
                endcase
            end
            OP_ORI, OP_LUI: w_res_dec = RES_ALU;
            OP_LW:          w_res_dec = RES_DM;
            OP_JAL:         w_res_dec = RES_PC;
`ifdef MW_PIPE_REG_LOADEXT_EN
            OP_LB, OP_LBU, OP_LH, OP_LHU: w_res_dec = RES_DM;
`endif
            default:        w_res_dec = RES_NW;
        endcase
    end

    // Pipeline register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            r_ir       <= '0;
            r_pc8      <= PC8_RST;
            r_ao       <= '0;
            r_dr       <= '0;
            r_rfa3     <= '0;
            r_res      <= RES_NW;
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!bus.stall_i) begin
            r_ir       <= bus.ir_i;
            r_pc8      <= bus.pc8_i;
            r_ao       <= bus.ao_i;
            r_dr       <= bus.dr_i;
            r_rfa3     <= bus.rfa3_i;
            r_res      <= w_res_dec;
            r_valid    <= 1'b1;
            r_regwrite <= bus.regwrite_i;
        end
    end

    // Retire the W-stage instruction when it leaves; a stalled one is counted only once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (r_valid && !bus.stall_i) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

`ifdef MW_PIPE_REG_LOADEXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian sub-word select, then sign/zero extension by opcode
    always_comb begin
        case (r_ao[1:0])
            2'd0:    w_byte = r_dr[7:0];
            2'd1:    w_byte = r_dr[15:8];
            2'd2:    w_byte = r_dr[23:16];
            default: w_byte = r_dr[31:24];
        endcase
        w_half = r_ao[1] ? r_dr[31:16] : r_dr[15:0];
        case (r_ir[31:26])
            OP_LB:   w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            OP_LH:   w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load_data = r_dr;
        endcase
    end
`else
    assign w_load_data = r_dr;
`endif

    // Register-file write data, selected from registered state only
    always_comb begin
        case (r_res)
            RES_ALU: w_wd = r_ao;
            RES_DM:  w_wd = w_load_data;
            RES_PC:  w_wd = r_pc8;
            default: w_wd = '0;
        endcase
    end

    // Never write $zero, and only for instructions that produce a result
    assign w_we = r_valid & r_regwrite & (r_rfa3 != '0) & (r_res != RES_NW);

    assign bus.ir_w      = r_ir;
    assign bus.pc8_w     = r_pc8;
    assign bus.ao_w      = r_ao;
    assign bus.dr_w      = r_dr;
    assign bus.rfa3_w    = r_rfa3;
    assign bus.res_w     = r_res;
    assign bus.valid_w   = r_valid;
    assign bus.we_w      = w_we;
    assign bus.wd_w      = w_wd;
    assign bus.retired_o = r_retired;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Scoreboard bench for mw_pipe_reg: stimulus pushes expected W-stage state,
// a monitor pops and compares one cycle later. Counter width is 4 to exercise wrap.
module tb_mw_pipe_reg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 4;

    logic clk;
    logic reset;

    mw_pipe_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    mw_pipe_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .PC8_RST (32'h0000_3008),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir, pc8, ao, dr, wd;
        logic [4:0]  rfa3;
        logic [1:0]  res;
        logic        valid, we;
        logic [3:0]  ret;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ir, m_pc8, m_ao, m_dr;
    logic [4:0]  m_rfa3;
    int          m_cls;   // 0 NW, 1 ALU, 2 DM, 3 PC
    bit          m_valid, m_rw;
    int          m_cnt;

    function automatic int classify(logic [31:0] ir);
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'd0 && (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001010)) return 1;
        if (op == 6'd0 && fn == 6'b001001) return 3;
        if (op == 6'b001101 || op == 6'b001111) return 1;
        if (op == 6'b100011) return 2;
        if (op == 6'b000011) return 3;
`ifdef MW_PIPE_REG_LOADEXT_EN
        if (op == 6'b100000 || op == 6'b100100 || op == 6'b100001 || op == 6'b100101) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [31:0] load_value(logic [31:0] ir, logic [31:0] ao, logic [31:0] dr);
        logic [31:0] b, h;
        b = (dr >> (8 * ao[1:0])) & 32'hFF;
        h = (dr >> (16 * ao[1])) & 32'hFFFF;
`ifdef MW_PIPE_REG_LOADEXT_EN
        case (ir[31:26])
            6'b100000: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            6'b100100: return b;
            6'b100001: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            6'b100101: return h;
            default:   return dr;
        endcase
`else
        if (ir == 32'hFFFF_FFFF && b == h) return dr;  // sub-word extraction unused
        return dr;
`endif
    endfunction

    task automatic model_bubble();
        m_ir = 0; m_pc8 = 32'h0000_3008; m_ao = 0; m_dr = 0; m_rfa3 = 0;
        m_cls = 0; m_valid = 0; m_rw = 0;
    endtask

    task automatic model_edge(bit rst, bit st, bit fl, logic [31:0] ir, logic [31:0] pc8,
                              logic [31:0] ao, logic [31:0] dr, logic [4:0] rfa3, bit rw);
        if (rst) begin
            model_bubble();
            m_cnt = 0;
        end else begin
            if (m_valid && !st) m_cnt = m_cnt + 1;
            if (fl) model_bubble();
            else if (!st) begin
                m_ir = ir; m_pc8 = pc8; m_ao = ao; m_dr = dr; m_rfa3 = rfa3;
                m_cls = classify(ir); m_valid = 1; m_rw = rw;
            end
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.ir = m_ir; e.pc8 = m_pc8; e.ao = m_ao; e.dr = m_dr; e.rfa3 = m_rfa3;
        e.res = 2'(m_cls);
        e.valid = m_valid;
        e.we = m_valid && m_rw && (m_rfa3 != 0) && (m_cls != 0);
        case (m_cls)
            1:       e.wd = m_ao;
            2:       e.wd = load_value(m_ir, m_ao, m_dr);
            3:       e.wd = m_pc8;
            default: e.wd = 0;
        endcase
        e.ret = 4'(m_cnt % 16);
        return e;
    endfunction

    // One clock of stimulus: drive on the falling edge, predict the next W state
    task automatic cycle(bit rst, bit st, bit fl, logic [31:0] ir, logic [31:0] pc8,
                         logic [31:0] ao, logic [31:0] dr, logic [4:0] rfa3, bit rw);
        @(negedge clk);
        reset = rst;
        bus.stall_i = st; bus.flush_i = fl;
        bus.ir_i = ir; bus.pc8_i = pc8; bus.ao_i = ao; bus.dr_i = dr;
        bus.rfa3_i = rfa3; bus.regwrite_i = rw;
        model_edge(rst, st, fl, ir, pc8, ao, dr, rfa3, rw);
        exp_q.push_back(model_expect());
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare after every active edge that has a prediction pending
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ir_w",      bus.ir_w,      e.ir);
                chk("pc8_w",     bus.pc8_w,     e.pc8);
                chk("ao_w",      bus.ao_w,      e.ao);
                chk("dr_w",      bus.dr_w,      e.dr);
                chk("rfa3_w",    32'(bus.rfa3_w),    32'(e.rfa3));
                chk("res_w",     32'(bus.res_w),     32'(e.res));
                chk("valid_w",   32'(bus.valid_w),   32'(e.valid));
                chk("we_w",      32'(bus.we_w),      32'(e.we));
                chk("wd_w",      bus.wd_w,      e.wd);
                chk("retired_o", 32'(bus.retired_o), 32'(e.ret));
            end
        end
    end

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0:  return {6'd0, r[25:6], 6'b100001};  // addu
            1:  return {6'd0, r[25:6], 6'b100011};  // subu
            2:  return {6'd0, r[25:6], 6'b001010};  // movz
            3:  return {6'd0, r[25:6], 6'b001001};  // jalr
            4:  return {6'd0, r[25:6], 6'b100100};  // and: no write-back class
            5:  return {6'b001101, r[25:0]};        // ori
            6:  return {6'b001111, r[25:0]};        // lui
            7:  return {6'b100011, r[25:0]};        // lw
            8:  return {6'b000011, r[25:0]};        // jal
            9:  return {6'b100000, r[25:0]};        // lb
            10: return {6'b100100, r[25:0]};        // lbu
            11: return {6'b100001, r[25:0]};        // lh
            12: return {6'b100101, r[25:0]};        // lhu
            13: return {6'b101011, r[25:0]};        // sw
            14: return {6'b000100, r[25:0]};        // beq
            default: return r;
        endcase
    endfunction

    localparam logic [31:0] ADDU_R8 = {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'b100001};
    localparam logic [31:0] ADDU_R0 = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001};
    localparam logic [31:0] JAL     = {6'b000011, 26'h40};
    localparam logic [31:0] LW      = {6'b100011, 5'd3, 5'd9, 16'h10};
    localparam logic [31:0] LB      = {6'b100000, 5'd3, 5'd10, 16'h2};
    localparam logic [31:0] LHU     = {6'b100101, 5'd3, 5'd11, 16'h2};

    initial begin
        reset = 1'b1;
        bus.stall_i = 0; bus.flush_i = 0; bus.ir_i = 0; bus.pc8_i = 0;
        bus.ao_i = 0; bus.dr_i = 0; bus.rfa3_i = 0; bus.regwrite_i = 0;
        m_cnt = 0;
        model_bubble();

        // Reset held two cycles
        cycle(1, 0, 0, 32'hDEAD_BEEF, 32'h5555, 32'h1, 32'h2, 5'd3, 1);
        cycle(1, 0, 0, 32'hDEAD_BEEF, 32'h5555, 32'h1, 32'h2, 5'd3, 1);
        // addu to $8, then a nop so the retirement shows up
        cycle(0, 0, 0, ADDU_R8, 32'h3010, 32'h1234, 32'h0, 5'd8, 1);
        cycle(0, 0, 0, 32'h0, 32'h3014, 32'h0, 32'h0, 5'd0, 0);
        // jal links $31; addu to $0 must not write
        cycle(0, 0, 0, JAL, 32'h3010, 32'h77, 32'h0, 5'd31, 1);
        cycle(0, 0, 0, ADDU_R0, 32'h3018, 32'h99, 32'h0, 5'd0, 1);
        // lw then three stalled cycles with changing inputs, then release
        cycle(0, 0, 0, LW, 32'h301C, 32'h100, 32'hCAFE_F00D, 5'd9, 1);
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, rand_ir(), $urandom, $urandom, $urandom, 5'($urandom), 1);
        cycle(0, 0, 0, 32'h0, 32'h3020, 32'h0, 32'h0, 5'd0, 0);
        // flush wins over stall
        cycle(0, 1, 1, ADDU_R8, 32'h3024, 32'h55, 32'h0, 5'd8, 1);
        // sub-word loads
        cycle(0, 0, 0, LB, 32'h3028, 32'h0000_0102, 32'h80FF_7F01, 5'd10, 1);
        cycle(0, 0, 0, LHU, 32'h302C, 32'h0000_0102, 32'h80FF_7F01, 5'd11, 1);
        // 17 back-to-back retirements after reset wrap a 4-bit counter to 1
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        for (int i = 0; i < 18; i++)
            cycle(0, 0, 0, ADDU_R8, 32'(i), 32'(i * 3), 32'h0, 5'd8, 1);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0), rand_ir(), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom));
        end
        // Drain: every prediction must have been consumed by the monitor
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
